// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor
//   Independent safety checker for the four road light buses. Every clock it
//   checks each road for legal one-hot encoding, conflicting non-red roads,
//   legal R->G->Y->R sequencing and yellow/green/red dwell limits. The first
//   violation is latched as a sticky fault and mirrored on force_red so the
//   top level can override to all-red.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-high
//   clear        in   acknowledge a latched fault (only honoured when all roads read red)
//   light_m1..4  in   [2:0] road lights: 100 red, 010 yellow, 001 green
//   armed        out  monitor is actively checking
//   fault        out  sticky violation flag
//   fault_code   out  [2:0] first violation code, 0 = none
//   fault_road   out  [1:0] offending road index (0..3 = m1..m4)
//   force_red    out  all-red override request, equal to fault
module traffic_light_monitor #(
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned MIN_YELLOW = 2,
  parameter int unsigned MAX_YELLOW = 5,
  parameter int unsigned MAX_GREEN  = 10,
  parameter int unsigned MAX_RED    = 40,
  parameter logic [15:0] COMPAT     = 16'h0012
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic [2:0] light_m1,
  input  logic [2:0] light_m2,
  input  logic [2:0] light_m3,
  input  logic [2:0] light_m4,
  output logic       armed,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [1:0] fault_road,
  output logic       force_red
);

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  localparam logic [CNT_W-1:0] MIN_Y_C   = CNT_W'(MIN_YELLOW);
  localparam logic [CNT_W-1:0] MAX_Y_C   = CNT_W'(MAX_YELLOW);
  localparam logic [CNT_W-1:0] MAX_G_C   = CNT_W'(MAX_GREEN);
  localparam logic [CNT_W-1:0] MAX_R_C   = CNT_W'(MAX_RED);
  localparam logic [CNT_W-1:0] DWELL_SAT = '1;
  localparam logic [CNT_W-1:0] DWELL_ONE = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, MONITOR, FAULT} state_e;

  state_e           state_q;
  logic             armed_q;
  logic             fault_q;
  logic [2:0]       code_q;
  logic [1:0]       road_q;
  logic [2:0]       prev_q  [4];
  logic [CNT_W-1:0] dwell_q [4];

  logic [2:0] light [4];
  logic [3:0] flag  [1:7];   // flag[code][road]
  logic       hit_d;
  logic [2:0] code_d;
  logic [1:0] road_d;
  logic       all_red;

  always_comb begin
    light[0] = light_m1;
    light[1] = light_m2;
    light[2] = light_m3;
    light[3] = light_m4;
  end

  always_comb begin
    for (int unsigned c = 1; c <= 7; c++) flag[c] = '0;
    all_red = 1'b1;
    for (int unsigned r = 0; r < 4; r++) begin
      if (light[r] != RED) all_red = 1'b0;
      if (!(light[r] == RED || light[r] == YEL || light[r] == GRN))
        flag[1][r] = 1'b1;
      // A conflicting pair is charged to its lower-indexed road.
      for (int unsigned j = r + 1; j < 4; j++)
        if (light[r] != RED && light[j] != RED && !COMPAT[r*4+j])
          flag[2][r] = 1'b1;
      if (light[r] != prev_q[r] &&
          !((prev_q[r] == RED && light[r] == GRN) ||
            (prev_q[r] == GRN && light[r] == YEL) ||
            (prev_q[r] == YEL && light[r] == RED)))
        flag[3][r] = 1'b1;
      if (prev_q[r] == YEL && light[r] == RED && dwell_q[r] < MIN_Y_C)
        flag[4][r] = 1'b1;
      if (prev_q[r] == YEL && light[r] == YEL && dwell_q[r] == MAX_Y_C)
        flag[5][r] = 1'b1;
      if (prev_q[r] == GRN && light[r] == GRN && dwell_q[r] == MAX_G_C)
        flag[6][r] = 1'b1;
      if (prev_q[r] == RED && light[r] == RED && dwell_q[r] == MAX_R_C)
        flag[7][r] = 1'b1;
    end
    // Lowest code first, then lowest road within that code.
    hit_d  = 1'b0;
    code_d = '0;
    road_d = '0;
    for (int unsigned c = 1; c <= 7; c++)
      for (int unsigned r = 0; r < 4; r++)
        if (!hit_d && flag[c][r]) begin
          hit_d  = 1'b1;
          code_d = 3'(c);
          road_d = 2'(r);
        end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      armed_q <= 1'b0;
      fault_q <= 1'b0;
      code_q  <= '0;
      road_q  <= '0;
      for (int unsigned r = 0; r < 4; r++) begin
        prev_q[r]  <= RED;
        dwell_q[r] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          for (int unsigned r = 0; r < 4; r++) begin
            prev_q[r]  <= light[r];
            dwell_q[r] <= DWELL_ONE;
          end
          state_q <= MONITOR;
          armed_q <= 1'b1;
        end
        MONITOR: begin
          for (int unsigned r = 0; r < 4; r++) begin
            prev_q[r] <= light[r];
            if (light[r] != prev_q[r])
              dwell_q[r] <= DWELL_ONE;
            else if (dwell_q[r] != DWELL_SAT)
              dwell_q[r] <= dwell_q[r] + 1'b1;
          end
          if (hit_d) begin
            state_q <= FAULT;
            armed_q <= 1'b0;
            fault_q <= 1'b1;
            code_q  <= code_d;
            road_q  <= road_d;
          end
        end
        FAULT: begin
          if (clear && all_red) begin
            for (int unsigned r = 0; r < 4; r++) begin
              prev_q[r]  <= light[r];
              dwell_q[r] <= DWELL_ONE;
            end
            state_q <= MONITOR;
            armed_q <= 1'b1;
            fault_q <= 1'b0;
            code_q  <= '0;
            road_q  <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign armed      = armed_q;
  assign fault      = fault_q;
  assign fault_code = code_q;
  assign fault_road = road_q;
  assign force_red  = fault_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
module tb_traffic_light_monitor;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  logic       clk = 1'b0;
  logic       reset, clear;
  logic [2:0] light_m1, light_m2, light_m3, light_m4;
  logic       armed, fault, force_red;
  logic [2:0] fault_code;
  logic [1:0] fault_road;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    logic       rst;
    logic       clr;
    logic [2:0] m1, m2, m3, m4;
    logic       e_armed;
    logic       e_fault;
    logic [2:0] e_code;
    logic [1:0] e_road;
  } vec_t;

  vec_t tbl [24];

  traffic_light_monitor #(
    .CNT_W(8), .MIN_YELLOW(2), .MAX_YELLOW(5), .MAX_GREEN(10), .MAX_RED(40),
    .COMPAT(16'h0012)
  ) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .light_m1(light_m1), .light_m2(light_m2), .light_m3(light_m3), .light_m4(light_m4),
    .armed(armed), .fault(fault), .fault_code(fault_code),
    .fault_road(fault_road), .force_red(force_red)
  );

  always #5 clk = ~clk;

  function automatic vec_t mkv(input logic rst, input logic clr,
                               input logic [2:0] a, input logic [2:0] b,
                               input logic [2:0] c, input logic [2:0] d,
                               input logic ea, input logic ef,
                               input logic [2:0] ec, input logic [1:0] er);
    vec_t v;
    v.rst = rst; v.clr = clr;
    v.m1 = a; v.m2 = b; v.m3 = c; v.m4 = d;
    v.e_armed = ea; v.e_fault = ef; v.e_code = ec; v.e_road = er;
    return v;
  endfunction

  // Drive one cycle of inputs, then check the registered outputs just after the edge.
  task automatic apply(input vec_t v, input string nm);
    reset = v.rst; clear = v.clr;
    light_m1 = v.m1; light_m2 = v.m2; light_m3 = v.m3; light_m4 = v.m4;
    @(posedge clk);
    #1;
    n_vec++;
    if ({armed, fault, fault_code, fault_road, force_red} !==
        {v.e_armed, v.e_fault, v.e_code, v.e_road, v.e_fault}) begin
      n_miss++;
      $display("FAIL %s: got armed=%b fault=%b code=%0d road=%0d force_red=%b, want armed=%b fault=%b code=%0d road=%0d force_red=%b",
               nm, armed, fault, fault_code, fault_road, force_red,
               v.e_armed, v.e_fault, v.e_code, v.e_road, v.e_fault);
    end
  endtask

  initial begin
    vec_t v;
    logic [2:0] a, c, d;
    int p;

    //                 rst clr m1     m2 m3 m4      armed fault code road
    tbl[0]  = mkv(1, 0, R, R, R, R,          0, 0, 0, 0); // reset state
    tbl[1]  = mkv(0, 0, R, R, R, R,          1, 0, 0, 0); // IDLE -> MONITOR
    tbl[2]  = mkv(0, 0, G, R, G, R,          0, 1, 2, 0); // m1/m3 conflict
    tbl[3]  = mkv(0, 1, R, R, R, R,          1, 0, 0, 0); // clear all-red
    tbl[4]  = mkv(0, 0, G, G, R, R,          1, 0, 0, 0); // m1+m2 compatible
    tbl[5]  = mkv(0, 0, Y, Y, R, R,          1, 0, 0, 0);
    tbl[6]  = mkv(0, 0, Y, Y, R, R,          1, 0, 0, 0);
    tbl[7]  = mkv(0, 0, R, R, R, R,          1, 0, 0, 0); // yellow dwell 2 ok
    tbl[8]  = mkv(0, 0, R, G, R, R,          1, 0, 0, 0);
    tbl[9]  = mkv(0, 0, R, R, R, R,          0, 1, 3, 1); // m2 G->R
    tbl[10] = mkv(0, 1, R, R, R, R,          1, 0, 0, 0);
    tbl[11] = mkv(0, 0, R, R, R, 3'b110,     0, 1, 1, 3); // illegal enc on m4
    tbl[12] = mkv(0, 1, G, R, R, R,          0, 1, 1, 3); // clear blocked
    tbl[13] = mkv(0, 1, R, R, R, R,          1, 0, 0, 0);
    tbl[14] = mkv(0, 0, Y, R, G, R,          0, 1, 2, 0); // code2 beats code3
    tbl[15] = mkv(1, 0, Y, R, G, R,          0, 0, 0, 0); // reset over fault
    tbl[16] = mkv(0, 0, R, R, R, R,          1, 0, 0, 0);
    tbl[17] = mkv(0, 0, 3'b011, R, G, R,     0, 1, 1, 0); // code1 beats code2
    tbl[18] = mkv(1, 0, R, R, R, R,          0, 0, 0, 0);
    tbl[19] = mkv(0, 0, R, R, R, R,          1, 0, 0, 0);
    tbl[20] = mkv(0, 0, R, R, G, R,          1, 0, 0, 0);
    tbl[21] = mkv(0, 0, R, R, Y, R,          1, 0, 0, 0);
    tbl[22] = mkv(0, 0, R, R, R, R,          0, 1, 4, 2); // yellow short
    tbl[23] = mkv(0, 1, R, R, R, R,          1, 0, 0, 0);

    for (int i = 0; i < 24; i++) apply(tbl[i], $sformatf("tbl[%0d]", i));

    // Yellow held 6 cycles on m3: fault on the 6th yellow sample.
    apply(mkv(0, 0, R, R, G, R, 1, 0, 0, 0), "ylong_g");
    for (int i = 0; i < 5; i++) apply(mkv(0, 0, R, R, Y, R, 1, 0, 0, 0), $sformatf("ylong_y%0d", i + 1));
    apply(mkv(0, 0, R, R, Y, R, 0, 1, 5, 2), "ylong_fault");
    apply(mkv(0, 1, R, R, R, R, 1, 0, 0, 0), "ylong_clear");

    // Green held 11 cycles on m3.
    for (int i = 0; i < 10; i++) apply(mkv(0, 0, R, R, G, R, 1, 0, 0, 0), $sformatf("glong_g%0d", i + 1));
    apply(mkv(0, 0, R, R, G, R, 0, 1, 6, 2), "glong_fault");
    apply(mkv(0, 1, R, R, R, R, 1, 0, 0, 0), "glong_clear");

    // m4 starved while m1/m2 and m3 cycle legally; 40th sample after clear trips.
    for (int k = 0; k < 40; k++) begin
      p = k % 22;
      a = (p < 8) ? G : (p < 11) ? Y : R;
      c = (p >= 11 && p < 19) ? G : (p >= 19) ? Y : R;
      if (k == 39) v = mkv(0, 0, a, a, c, R, 0, 1, 7, 3);
      else         v = mkv(0, 0, a, a, c, R, 1, 0, 0, 0);
      apply(v, $sformatf("starve_k%0d", k));
    end
    apply(mkv(0, 1, G, R, R, R, 0, 1, 7, 3), "starve_clear_blocked");
    apply(mkv(0, 1, R, R, R, R, 1, 0, 0, 0), "starve_clear");
    apply(mkv(0, 0, R, R, R, R, 1, 0, 0, 0), "starve_rearmed");

    // Legal rotation m1+m2, m3, m4 (G8, Y3 each) for 200 cycles after a fresh reset.
    apply(mkv(1, 0, R, R, R, R, 0, 0, 0, 0), "cycle_reset");
    apply(mkv(0, 0, R, R, R, R, 1, 0, 0, 0), "cycle_arm");
    for (int k = 0; k < 200; k++) begin
      p = k % 33;
      a = (p < 8) ? G : (p < 11) ? Y : R;
      c = (p >= 11 && p < 19) ? G : (p >= 19 && p < 22) ? Y : R;
      d = (p >= 22 && p < 30) ? G : (p >= 30) ? Y : R;
      apply(mkv(0, 0, a, a, c, d, 1, 0, 0, 0), $sformatf("cycle_k%0d", k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
